// File: rtl/dcache_resp.sv
// Data-cache response path: one-entry request buffer toward memory plus a
// two-deep in-order tag FIFO that matches memory responses back to CPU requests.
module dcache_resp (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_cache_req,
  input  logic        data_cache_wr,
  input  logic [1:0]  data_cache_size,
  input  logic [31:0] data_cache_addr,
  input  logic [3:0]  data_cache_wstrb,
  input  logic [31:0] data_cache_wdata,
  output logic        data_cache_addr_ok,
  output logic        data_cache_data_ok,
  output logic [31:0] data_cache_rdata,
  input  logic        ms_cancel,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  logic        buf_v_r;
  logic        buf_wr_r;
  logic [1:0]  buf_size_r;
  logic [31:0] buf_addr_r;
  logic [3:0]  buf_wstrb_r;
  logic [31:0] buf_wdata_r;

  logic [1:0]  tag_wr_r;
  logic [1:0]  tag_disc_r;
  logic        head_r;
  logic        tail_r;
  logic [1:0]  count_r;

  logic        data_ok_r;
  logic [31:0] rdata_r;

  logic [1:0]  inflight_s;
  logic        addr_ok_s;
  logic        accept_s;
  logic        push_s;
  logic        pop_s;
  logic        pop_wr_s;
  logic        pop_disc_s;
  logic        respond_s;
  logic [1:0]  count_nxt_s;

  // Handshake decode; a flush forces the popped entry to be discarded.
  always_comb begin
    inflight_s = {1'b0, buf_v_r} + count_r;
    addr_ok_s  = !buf_v_r && (inflight_s < 2'd2) && !ms_cancel;
    accept_s   = data_cache_req && addr_ok_s;
    push_s     = buf_v_r && mem_addr_ok;
    pop_s      = mem_data_ok && (count_r != 2'd0);
    pop_wr_s   = tag_wr_r[head_r];
    pop_disc_s = tag_disc_r[head_r] || ms_cancel;
    respond_s  = pop_s && !pop_disc_s;
  end

  // FIFO occupancy; simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 2'd1;
      2'b01:   count_nxt_s = count_r - 2'd1;
      default: count_nxt_s = count_r;
    endcase
  end

  // Request buffer: held stable toward memory until accepted or flushed.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      buf_v_r     <= 1'b0;
      buf_wr_r    <= 1'b0;
      buf_size_r  <= 2'd0;
      buf_addr_r  <= 32'h0;
      buf_wstrb_r <= 4'h0;
      buf_wdata_r <= 32'h0;
    end else if (accept_s) begin
      buf_v_r     <= 1'b1;
      buf_wr_r    <= data_cache_wr;
      buf_size_r  <= data_cache_size;
      buf_addr_r  <= data_cache_addr;
      buf_wstrb_r <= data_cache_wstrb;
      buf_wdata_r <= data_cache_wdata;
    end else if (push_s || ms_cancel) begin
      buf_v_r     <= 1'b0;
    end
  end

  // Tag FIFO; a flush marks every outstanding entry, including one pushed now.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_wr_r   <= 2'b00;
      tag_disc_r <= 2'b00;
      head_r     <= 1'b0;
      tail_r     <= 1'b0;
      count_r    <= 2'd0;
    end else begin
      if (ms_cancel) begin
        tag_disc_r <= 2'b11;
      end
      if (push_s) begin
        tag_wr_r[tail_r]   <= buf_wr_r;
        tag_disc_r[tail_r] <= ms_cancel;
        tail_r             <= ~tail_r;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      count_r <= count_nxt_s;
    end
  end

  // CPU response register; rdata holds between responses, stores return zero.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok_r <= 1'b0;
      rdata_r   <= 32'h0;
    end else begin
      data_ok_r <= respond_s;
      if (respond_s) begin
        rdata_r <= pop_wr_s ? 32'h0 : mem_rdata;
      end
    end
  end

  assign data_cache_addr_ok = addr_ok_s;
  assign data_cache_data_ok = data_ok_r;
  assign data_cache_rdata   = rdata_r;
  assign mem_req            = buf_v_r;
  assign mem_wr             = buf_wr_r;
  assign mem_size           = buf_size_r;
  assign mem_addr           = buf_addr_r;
  assign mem_wstrb          = buf_wstrb_r;
  assign mem_wdata          = buf_wdata_r;

endmodule

// File: tb/tb_dcache_resp.sv
// Scoreboard bench for dcache_resp: a queue-level reference model predicts
// handshakes and responses; a separate monitor checks every data_ok.
module tb_dcache_resp;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_cache_req;
  logic        data_cache_wr;
  logic [1:0]  data_cache_size;
  logic [31:0] data_cache_addr;
  logic [3:0]  data_cache_wstrb;
  logic [31:0] data_cache_wdata;
  logic        data_cache_addr_ok;
  logic        data_cache_data_ok;
  logic [31:0] data_cache_rdata;
  logic        ms_cancel;
  logic        mem_req;
  logic        mem_wr;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  dcache_resp dut (
    .clk(clk), .resetn(resetn),
    .data_cache_req(data_cache_req), .data_cache_wr(data_cache_wr),
    .data_cache_size(data_cache_size), .data_cache_addr(data_cache_addr),
    .data_cache_wstrb(data_cache_wstrb), .data_cache_wdata(data_cache_wdata),
    .data_cache_addr_ok(data_cache_addr_ok), .data_cache_data_ok(data_cache_data_ok),
    .data_cache_rdata(data_cache_rdata), .ms_cancel(ms_cancel),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic wr;
    logic cancel;
  } tag_t;

  req_t        acc_q[$];   // accepted, not yet taken by memory
  tag_t        mem_q[$];   // taken by memory, awaiting response
  logic [31:0] exp_q[$];   // responses the CPU must see, in order
  int          errors = 0;
  int          checks = 0;
  logic [31:0] mon_exp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // One bus cycle: drive inputs, then check outputs and advance the model.
  task automatic step(input logic req, input logic wr, input logic [1:0] size,
                      input logic [31:0] addr, input logic [3:0] wstrb,
                      input logic [31:0] wdata, input logic aok, input logic dok,
                      input logic [31:0] rd, input logic cancel);
    req_t r;
    tag_t t;
    logic exp_aok;
    logic hs;
    @(negedge clk);
    data_cache_req   = req;
    data_cache_wr    = wr;
    data_cache_size  = size;
    data_cache_addr  = addr;
    data_cache_wstrb = wstrb;
    data_cache_wdata = wdata;
    mem_addr_ok      = aok;
    mem_data_ok      = dok;
    mem_rdata        = rd;
    ms_cancel        = cancel;
    #1;
    exp_aok = (acc_q.size() == 0) && ((acc_q.size() + mem_q.size()) < 2) && !cancel;
    chk("addr_ok", 32'(data_cache_addr_ok), 32'(exp_aok));
    chk("mem_req", 32'(mem_req), 32'(acc_q.size() != 0));
    if (acc_q.size() != 0) begin
      r = acc_q[0];
      chk("mem_addr", mem_addr, r.addr);
      chk("mem_wr", 32'(mem_wr), 32'(r.wr));
      chk("mem_size", 32'(mem_size), 32'(r.size));
      chk("mem_wstrb", 32'(mem_wstrb), 32'(r.wstrb));
      chk("mem_wdata", mem_wdata, r.wdata);
    end
    hs = (acc_q.size() != 0) && aok;
    if (dok && mem_q.size() != 0) begin
      t = mem_q.pop_front();
      if (!t.cancel && !cancel) exp_q.push_back(t.wr ? 32'h0 : rd);
    end
    if (hs) begin
      r = acc_q.pop_front();
      t.wr = r.wr;
      t.cancel = cancel;
      mem_q.push_back(t);
    end
    if (cancel) begin
      acc_q.delete();
      foreach (mem_q[i]) mem_q[i].cancel = 1'b1;
    end
    if (req && exp_aok) begin
      r.wr = wr; r.size = size; r.addr = addr; r.wstrb = wstrb; r.wdata = wdata;
      acc_q.push_back(r);
    end
  endtask

  task automatic idle(input logic aok, input logic dok, input logic [31:0] rd);
    step(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, aok, dok, rd, 1'b0);
  endtask

  task automatic load(input logic [31:0] addr);
    step(1'b1, 1'b0, 2'd2, addr, 4'hF, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset in mid-cycle; everything in flight is forgotten.
  task automatic mid_reset();
    @(negedge clk);
    data_cache_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; ms_cancel = 1'b0;
    #2 resetn = 1'b0;
    #1;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_data_ok", 32'(data_cache_data_ok), 32'd0);
    chk("rst_rdata", data_cache_rdata, 32'h0);
    chk("rst_addr_ok", 32'(data_cache_addr_ok), 32'd1);
    acc_q.delete();
    mem_q.delete();
    exp_q.delete();
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: every data_ok must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (resetn && data_cache_data_ok) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_data_ok: got rdata %h expected no response (t=%0t)",
                 data_cache_rdata, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("rdata", data_cache_rdata, mon_exp);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    data_cache_req = 1'b0; data_cache_wr = 1'b0; data_cache_size = 2'd0;
    data_cache_addr = 32'h0; data_cache_wstrb = 4'h0; data_cache_wdata = 32'h0;
    ms_cancel = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset_data_ok", 32'(data_cache_data_ok), 32'd0);
    chk("reset_rdata", data_cache_rdata, 32'h0);
    chk("reset_mem_req", 32'(mem_req), 32'd0);
    resetn = 1'b1;

    // Single load, minimum latency.
    load(32'h0000_1000);
    idle(1'b1, 1'b0, 32'h0);
    idle(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk("lat_no_early", 32'(data_cache_data_ok), 32'd0);
    idle(1'b0, 1'b0, 32'h0);
    chk("lat_data_ok", 32'(data_cache_data_ok), 32'd1);
    chk("lat_rdata", data_cache_rdata, 32'hDEAD_BEEF);
    idle(1'b0, 1'b0, 32'h0);
    chk("lat_pulse", 32'(data_cache_data_ok), 32'd0);

    // Back-to-back loads fill the pipe; a third request waits.
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b0, 2'd2, 32'h2000 + 32'(i * 4), 4'hF, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
    chk("full_addr_ok", 32'(data_cache_addr_ok), 32'd0);
    idle(1'b0, 1'b1, 32'h1111_0000);
    idle(1'b0, 1'b1, 32'h2222_0000);
    repeat (2) idle(1'b0, 1'b0, 32'h0);

    // Store returns zero data.
    step(1'b1, 1'b1, 2'd1, 32'h3000, 4'b0011, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 1'b0);
    idle(1'b1, 1'b0, 32'h0);
    chk("store_wstrb", 32'(mem_wstrb), 32'h3);
    chk("store_wr", 32'(mem_wr), 32'd1);
    idle(1'b0, 1'b1, 32'h5555_5555);
    idle(1'b0, 1'b0, 32'h0);
    chk("store_data_ok", 32'(data_cache_data_ok), 32'd1);
    chk("store_rdata", data_cache_rdata, 32'h0);

    // Flush with two loads outstanding.
    load(32'h5000);
    idle(1'b1, 1'b0, 32'h0);
    load(32'h5004);
    idle(1'b1, 1'b0, 32'h0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b0, 1'b1, 32'hAAAA_0001);
    idle(1'b0, 1'b1, 32'hAAAA_0002);
    idle(1'b0, 1'b0, 32'h0);
    chk("flush_no_resp", 32'(exp_q.size()), 32'd0);
    chk("flush_data_ok", 32'(data_cache_data_ok), 32'd0);
    load(32'h5008);
    idle(1'b1, 1'b0, 32'h0);
    idle(1'b0, 1'b1, 32'h1234_5678);
    repeat (2) idle(1'b0, 1'b0, 32'h0);

    // Memory stalls; request fields must hold, then a flush drops it.
    load(32'h6000);
    for (int i = 0; i < 5; i++)
      step(1'b1, 1'b1, 2'd0, 32'h7000 + 32'(i), 4'h1, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 2'd0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(1'b0, 1'b0, 32'h0);
    chk("stall_flush_req", 32'(mem_req), 32'd0);

    // Reset with one entry in the FIFO, then a stray memory response.
    load(32'h8000);
    idle(1'b1, 1'b0, 32'h0);
    mid_reset();
    idle(1'b0, 1'b1, 32'h0BAD_0BAD);
    idle(1'b0, 1'b0, 32'h0);
    chk("stray_data_ok", 32'(data_cache_data_ok), 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 9) < 6), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
           $urandom, 4'($urandom), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 9) < 4), $urandom, 1'($urandom_range(0, 19) == 0));

    repeat (10) idle(1'b1, 1'b1, $urandom);
    repeat (2) idle(1'b0, 1'b0, 32'h0);
    chk("drain_all_responses", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_resp.md
DCACHE_RESP -- requirements
Module: dcache_resp

Interface
REQ-001 clk  in  1  sole clock; all state updates on the rising edge.
REQ-002 resetn  in  1  asynchronous, active-low reset.
REQ-003 data_cache_req  in  1  CPU data request valid.
REQ-004 data_cache_wr  in  1  1=store, 0=load.
REQ-005 data_cache_size  in  2  0=byte, 1=half, 2=word.
REQ-006 data_cache_addr  in  32  byte address.
REQ-007 data_cache_wstrb  in  4  store byte enables.
REQ-008 data_cache_wdata  in  32  store data.
REQ-009 data_cache_addr_ok  out  1  request accepted this cycle.
REQ-010 data_cache_data_ok  out  1  response valid, registered, one-cycle pulse.
REQ-011 data_cache_rdata  out  32  raw aligned word; MEM stage extracts bytes.
REQ-012 ms_cancel  in  1  pipeline flush (exception, eret, cancel).
REQ-013 mem_req, mem_wr  out  1 each  memory-side request and direction.
REQ-014 mem_size  out  2;  mem_addr  out  32;  mem_wstrb  out  4;  mem_wdata  out  32;  forwarded request fields.
REQ-015 mem_addr_ok  in  1  memory accepted request.
REQ-016 mem_data_ok  in  1  memory response valid, in order.
REQ-017 mem_rdata  in  32  memory read data.

Function
REQ-018 Request buffer: one entry holding {wr, size, addr, wstrb, wdata}, valid flag buf_v.
REQ-019 Tag FIFO: depth 2, in-order, entry = {wr, discard}; head/tail pointers wrap modulo 2; count 0..2.
REQ-020 inflight = buf_v + FIFO count; inflight SHALL never exceed 2.
REQ-021 data_cache_addr_ok = !buf_v && inflight<2 && !ms_cancel (combinational); acceptance = data_cache_req && data_cache_addr_ok; sets buf_v and captures fields next edge.
REQ-022 mem_req = buf_v; mem_* fields driven from buffer, stable while mem_req && !mem_addr_ok.
REQ-023 On mem_req && mem_addr_ok: clear buf_v; push {wr, discard=ms_cancel}.
REQ-024 On mem_data_ok with FIFO nonempty: pop head; if !discard, next cycle data_cache_data_ok=1 and data_cache_rdata = wr ? 32'h0 : mem_rdata; otherwise no data_ok.
REQ-025 mem_data_ok with FIFO empty SHALL be ignored (no state change, no data_ok).
REQ-026 Push and pop in the same cycle SHALL both take effect; count unchanged.
REQ-027 ms_cancel: buf_v cleared unless its handshake completes that cycle (then pushed with discard=1); all FIFO entries set discard=1; data_cache_data_ok forced 0 next cycle; no new acceptance that cycle.
REQ-028 ms_cancel coincident with mem_data_ok: the popped entry is discarded.
REQ-029 data_cache_data_ok SHALL be 0 in every cycle without a qualifying pop in the prior cycle; rdata holds last value otherwise.
REQ-030 Minimum latency: accept at T, mem_req at T+1, mem_data_ok earliest T+2, data_cache_data_ok at T+3.
REQ-031 Responses to CPU SHALL return in acceptance order; one data_ok per non-discarded request.

Reset
REQ-032 resetn low SHALL immediately clear buf_v, FIFO pointers/count, discard bits, data_cache_data_ok, mem_req.
REQ-033 data_cache_rdata resets to 32'h0; data_cache_addr_ok = 1 once resetn high (req permitting).
REQ-034 Reset asserted mid-transaction drops all in-flight state; later mem_data_ok with empty FIFO is ignored per REQ-025.

Verification
REQ-035 Load addr 0x1000, mem_addr_ok same cycle, mem_data_ok at T+2 with rdata 0xDEADBEEF -> data_ok pulse at T+3, rdata 0xDEADBEEF.
REQ-036 Two back-to-back loads, mem_addr_ok held 1, data_ok withheld -> third req sees addr_ok=0 until first mem_data_ok; responses return in order.
REQ-037 Store with wstrb 4'b0011 -> mem_wstrb 4'b0011, mem_wr=1; response gives data_ok=1, rdata=0.
REQ-038 Two loads outstanding, ms_cancel pulse, then two mem_data_ok -> no data_ok; FIFO empty; next request accepted normally.
REQ-039 mem_addr_ok held low 5 cycles -> mem_* fields stable, addr_ok=0 throughout; ms_cancel during hold -> mem_req drops next cycle.
REQ-040 resetn asserted with one entry in FIFO, released, stray mem_data_ok -> ignored; data_ok stays 0.
